imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the counterpart to the fetch unit, which only reads instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes those words into the instruction memory write port, starting at word 0.
- While loading, holds the fetch unit's PC (EN low). On completion, pulses a PC restart so fetch resumes at the boot address with the new program.

Parameters:
- DEPTH, 1024, number of 32-bit words in instruction memory.
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  in  ADDR_W+1  number of words to load; latched on an accepted start.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction memory write enable.
- im_addr  out  ADDR_W  word address of the write.
- im_wdata  out  32  write data.
- fetch_en  out  1  drives the fetch unit EN; low holds the PC.
- pc_restart  out  1  one-cycle pulse that resets the fetch PC to 0x3000.
- busy  out  1  a load is in progress.
- done  out  1  sticky flag: the last load completed.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; im_we=0; im_addr=0; im_wdata=0; byte_ready=0; fetch_en=1; pc_restart=0; busy=0; done=0; byte index=0; latched count=0.
- All outputs are registered or decoded from the state register only. No combinational path from byte_valid to byte_ready.
- IDLE:
  - byte_ready=0, fetch_en=1, busy=0.
  - On start: latch cnt = min(word_count, DEPTH), clear done, set addr=0 and byte index=0.
  - cnt==0 → FINISH; otherwise → LOAD.
- LOAD:
  - byte_ready=1, fetch_en=0, busy=1.
  - A byte is transferred when byte_valid && byte_ready: word <= {word[23:0], byte_in}, and the byte index increments mod 4.
  - The first byte received is the most significant byte.
  - When the 4th byte is transferred → WRITE.
  - byte_valid low stalls indefinitely; no timeout.
- WRITE (exactly one cycle):
  - im_we=1, im_addr=addr, im_wdata=word; byte_ready=0.
  - If addr == cnt-1 → FINISH; otherwise addr++ → LOAD.
- FINISH (one cycle):
  - pc_restart=1, fetch_en=0, busy=1, done<=1 → IDLE.
  - fetch_en returns to 1 in the following IDLE cycle.
- Latency and throughput:
  - The memory write occurs in the cycle after the 4th byte handshake.
  - A word takes at least 5 cycles (4 accept cycles + 1 write).
  - pc_restart occurs in the cycle after the final write.
- Boundary conditions:
  - start outside IDLE is ignored.
  - word_count > DEPTH is clamped to DEPTH. The address never wraps; at most DEPTH writes per load.
  - reset mid-load aborts immediately to the reset state. Words already written remain in memory. No pc_restart is issued. done=0.
  - A partial word (fewer than 4 bytes) at reset is discarded.
  - done stays high until the next accepted start or reset.
  - im_we is never high outside WRITE. im_addr and im_wdata hold their last values otherwise.

Decomposition:
- Shared package:
  - state encoding constants: IDLE, LOAD, WRITE, FINISH.
  - boot PC constant 32'h3000, shared with the fetch unit.
  - DEPTH/ADDR_W defaults, shared with the fetch unit's memory sizing.
- One natural sub-module: byte_packer, the 8-to-32 shift register plus 2-bit index with a word_valid strobe.
- The FSM, address counter and output decode stay in imem_loader.

Test Plan:
- Reset then idle: hold reset for 2 cycles → fetch_en=1, busy=0, done=0, im_we=0, byte_ready=0.
- Single word: start with word_count=1; bytes 0x24,0x08,0x00,0x05 sent back-to-back → one im_we pulse with im_addr=0 and im_wdata=0x24080005 in the cycle after the 4th byte; pc_restart pulses 1 cycle later; then done=1 and fetch_en=1.
- Multi-word with gaps: word_count=3; byte_valid toggles 1/0 each cycle → writes to addresses 0,1,2 in order with the correct big-endian words; fetch_en=0 throughout; exactly 3 im_we pulses.
- Zero count and clamp:
  - word_count=0 → no im_we; pc_restart after 1 cycle; done=1.
  - word_count=1500 → cnt latched as 1024; last write at im_addr=1023; no write wraps to address 0.
- Reset mid-load: word_count=4; assert reset after 6 bytes → no further im_we; word 0 written and word 1 discarded; no pc_restart; done=0; fetch_en=1.
- start while busy: pulse start during LOAD with a different word_count → ignored; the original count completes; done rises once.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared sizing, boot address and loader FSM encoding
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_ADDR_W = 10;

  // pc_restart makes the fetch unit reload its PC with this address
  localparam logic [31:0] BOOT_PC = 32'h0000_3000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian 8-to-32 packer with word strobe
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_next_o,
  output logic        word_valid_o
);

  // Only the three earlier bytes need storage; the fourth arrives with the strobe
  logic [23:0] word_q;
  logic [1:0]  idx_q;

  assign word_next_o  = {word_q, byte_i};
  assign word_valid_o = shift_en_i && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (shift_en_i) begin
      word_q <= word_next_o[23:0];
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams bytes into instruction memory and restarts fetch
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              fetch_en,
  output logic              pc_restart,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic              shift_en;
  logic              word_valid;
  logic [31:0]       word_next;
  logic [ADDR_W:0]   cnt_clamped;
  logic              last_word;

  assign start_ok    = (state_q == ST_IDLE) && start;
  assign shift_en    = (state_q == ST_LOAD) && byte_valid;
  assign cnt_clamped = (word_count > DEPTH_C) ? DEPTH_C : word_count;
  assign last_word   = ({1'b0, addr_q} == (cnt_q - (ADDR_W+1)'(1)));

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_ok),
    .shift_en_i   (shift_en),
    .byte_i       (byte_in),
    .word_next_o  (word_next),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = cnt_clamped;
          addr_d  = '0;
          done_d  = 1'b0;
          state_d = (cnt_clamped == '0) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Write-port registers load here so they stay stable outside WRITE
        if (word_valid) begin
          im_addr_d  = addr_q;
          im_wdata_d = word_next;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last_word) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      done_q     <= done_d;
    end
  end

  assign byte_ready = (state_q == ST_LOAD);
  assign im_we      = (state_q == ST_WRITE);
  assign pc_restart = (state_q == ST_FINISH);
  assign fetch_en   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign done       = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        fetch_en;
  logic        pc_restart;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int          wr_count = 0;
  int          pc_count = 0;
  int          addr0_writes = 0;
  int          fe_while_busy = 0;
  logic [9:0]  wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  logic [9:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .fetch_en   (fetch_en),
    .pc_restart (pc_restart),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we) begin
      if (wr_count < 8) begin
        wr_addr[wr_count] = im_addr;
        wr_data[wr_count] = im_wdata;
      end
      if (im_addr == 10'd0) addr0_writes = addr0_writes + 1;
      last_addr = im_addr;
      last_data = im_wdata;
      wr_count  = wr_count + 1;
    end
    if (pc_restart) pc_count = pc_count + 1;
    if (busy && fetch_en) fe_while_busy = fe_while_busy + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_count = 0;
    pc_count = 0;
    addr0_writes = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", byte_ready, 1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      if (gaps) tick();
    end
  endtask

  task automatic do_start(input logic [10:0] wc);
    start      = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  logic [31:0] multi [0:2];

  initial begin
    multi[0] = 32'h1122_3344;
    multi[1] = 32'hA5B6_C7D8;
    multi[2] = 32'h00FF_0102;

    // reset then idle
    reset = 1'b1;
    tick();
    tick();
    chk("rst_fetch_en", fetch_en, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_im_we", im_we, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_pc_restart", pc_restart, 0);
    reset = 1'b0;
    tick();
    chk("idle_fetch_en", fetch_en, 1);

    // single word, back-to-back bytes
    clear_mon();
    do_start(11'd1);
    chk("w1_byte_ready", byte_ready, 1);
    chk("w1_fetch_en", fetch_en, 0);
    chk("w1_busy", busy, 1);
    send_byte(8'h24);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    chk("w1_im_we", im_we, 1);
    chk("w1_im_addr", im_addr, 0);
    chk("w1_im_wdata", im_wdata, 32'h2408_0005);
    chk("w1_ready_in_write", byte_ready, 0);
    chk("w1_no_restart_yet", pc_restart, 0);
    tick();
    chk("w1_pc_restart", pc_restart, 1);
    chk("w1_we_off", im_we, 0);
    chk("w1_fin_fetch_en", fetch_en, 0);
    chk("w1_fin_busy", busy, 1);
    chk("w1_wdata_hold", im_wdata, 32'h2408_0005);
    tick();
    chk("w1_done", done, 1);
    chk("w1_fetch_en_back", fetch_en, 1);
    chk("w1_restart_off", pc_restart, 0);
    chk("w1_writes", wr_count, 1);

    // three words, byte_valid toggling
    clear_mon();
    fe_while_busy = 0;
    do_start(11'd3);
    chk("w3_done_cleared", done, 0);
    for (int w = 0; w < 3; w++) send_word(multi[w], 1'b1);
    wait_idle("w3_idle_timeout");
    chk("w3_writes", wr_count, 3);
    for (int w = 0; w < 3; w++) begin
      chk("w3_addr", wr_addr[w], w);
      chk("w3_data", wr_data[w], multi[w]);
    end
    chk("w3_fetch_en_low", fe_while_busy, 0);
    chk("w3_pc_count", pc_count, 1);
    chk("w3_done", done, 1);

    // zero count
    clear_mon();
    do_start(11'd0);
    chk("z_pc_restart", pc_restart, 1);
    chk("z_im_we", im_we, 0);
    tick();
    chk("z_done", done, 1);
    chk("z_writes", wr_count, 0);
    chk("z_idle", busy, 0);

    // clamp: 1500 requested, 1024 written
    clear_mon();
    do_start(11'd1500);
    for (int w = 0; w < 1024; w++) send_word(32'hCAFE_0000 | w, 1'b0);
    wait_idle("clamp_idle_timeout");
    chk("clamp_writes", wr_count, 1024);
    chk("clamp_last_addr", last_addr, 10'd1023);
    chk("clamp_last_data", last_data, 32'hCAFE_03FF);
    chk("clamp_no_wrap", addr0_writes, 1);
    chk("clamp_pc_count", pc_count, 1);
    chk("clamp_done", done, 1);
    repeat (10) tick();
    chk("clamp_no_extra", wr_count, 1024);

    // reset mid-load after 6 bytes
    clear_mon();
    do_start(11'd4);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b1;
    tick();
    chk("mr_fetch_en", fetch_en, 1);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_byte_ready", byte_ready, 0);
    reset = 1'b0;
    repeat (8) tick();
    chk("mr_writes", wr_count, 1);
    chk("mr_word0", wr_data[0], 32'hDEAD_BEEF);
    chk("mr_pc_count", pc_count, 0);
    chk("mr_done_after", done, 0);
    // partial word must not leak into the next load
    clear_mon();
    do_start(11'd1);
    send_word(32'h0102_0304, 1'b0);
    chk("mr_next_word", im_wdata, 32'h0102_0304);
    chk("mr_next_addr", im_addr, 0);
    wait_idle("mr_idle_timeout");

    // start during LOAD is ignored
    clear_mon();
    do_start(11'd2);
    send_byte(8'hAA);
    start      = 1'b1;
    word_count = 11'd5;
    send_byte(8'hBB);
    start = 1'b0;
    send_byte(8'hCC);
    send_byte(8'hDD);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'h5566_7788, 1'b0);
    wait_idle("sb_idle_timeout");
    repeat (10) tick();
    chk("sb_writes", wr_count, 2);
    chk("sb_word0", wr_data[0], 32'hAABB_CCDD);
    chk("sb_word1", wr_data[1], 32'h5566_7788);
    chk("sb_pc_count", pc_count, 1);
    chk("sb_done", done, 1);
    chk("sb_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
